// File: rtl/pcie_cq_cc_responder.sv
// ---------------------------------------------------------------------------
// pcie_cq_cc_responder
//
// User-side PCIe completer for the 64-bit UltraScale AXI4-Stream interface.
// Accepts requests on the completer-request (CQ) stream, executes single-DW
// memory writes and reads against an internal register file, and returns
// read completions on the completer-completion (CC) stream. One request is
// handled at a time; CQ is backpressured while a completion is being sent.
//
// Ports
//   pcie_clk_in          clock, all logic on the rising edge
//   pcie_reset_out       synchronous active-high reset
//   pcie_link_up         0 blocks acceptance of new requests (IDLE only)
//   m_axis_cq_*          CQ request stream in (tuser: [3:0] first_be, [40] sop)
//   s_axis_cc_*          CC completion stream out (tuser always 0)
//   cfg_completer_id     bus/dev/func placed in completion DW2
//   wr_cnt/rd_cnt/drop_cnt  accepted writes, successful reads, dropped requests
// ---------------------------------------------------------------------------
module pcie_cq_cc_responder #(
    parameter int PCIE_DATA_WIDTH = 64,
    parameter int PCIE_KEEP_WIDTH = PCIE_DATA_WIDTH / 32,
    parameter int REG_AW          = 6
) (
    input  logic                       pcie_clk_in,
    input  logic                       pcie_reset_out,
    input  logic                       pcie_link_up,

    input  logic [PCIE_DATA_WIDTH-1:0] m_axis_cq_tdata,
    input  logic [84:0]                m_axis_cq_tuser,
    input  logic                       m_axis_cq_tlast,
    input  logic [PCIE_KEEP_WIDTH-1:0] m_axis_cq_tkeep,
    input  logic                       m_axis_cq_tvalid,
    output logic                       m_axis_cq_tready,

    output logic [PCIE_DATA_WIDTH-1:0] s_axis_cc_tdata,
    output logic [84:0]                s_axis_cc_tuser,
    output logic                       s_axis_cc_tlast,
    output logic [PCIE_KEEP_WIDTH-1:0] s_axis_cc_tkeep,
    output logic                       s_axis_cc_tvalid,
    input  logic                       s_axis_cc_tready,

    input  logic [15:0]                cfg_completer_id,

    output logic [31:0]                wr_cnt,
    output logic [31:0]                rd_cnt,
    output logic [31:0]                drop_cnt
);

    localparam int DEPTH = 2 ** REG_AW;
    // Keep enough address bits for both the register index and the 7-bit
    // lower-address field of the completion.
    localparam int AW_HI = (REG_AW > 5) ? (REG_AW + 1) : 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_WDATA,
        ST_DRAIN,
        ST_CPL0,
        ST_CPL1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [AW_HI:2]    addr_reg;
    logic [3:0]        first_be_reg;
    logic [15:0]       req_id_reg;
    logic [7:0]        tag_reg;
    logic [2:0]        tc_reg;
    logic [2:0]        attr_reg;
    logic              ur_reg;
    logic [31:0]       wr_cnt_reg;
    logic [31:0]       rd_cnt_reg;
    logic [31:0]       drop_cnt_reg;

    logic              cq_ready;
    logic              cq_fire;
    logic              cc_fire;
    logic              cq_sop;
    logic [3:0]        req_type;
    logic [10:0]       req_dw_count;
    logic              is_mrd;
    logic              is_mwr;
    logic              is_single;
    logic              hdr_drop;
    logic              wr_en;
    logic [REG_AW-1:0] reg_idx;
    logic [31:0]       rd_data;
    logic [31:0]       cpl_dw0;
    logic [31:0]       cpl_dw1;
    logic [31:0]       cpl_dw2;
    logic              unused_cq_bits;

    // -----------------------------------------------------------------------
    // CQ request decode
    // -----------------------------------------------------------------------
    assign cq_sop       = m_axis_cq_tuser[40];
    assign req_dw_count = m_axis_cq_tdata[10:0];
    assign req_type     = m_axis_cq_tdata[14:11];
    assign is_mrd       = (req_type == 4'd0);
    assign is_mwr       = (req_type == 4'd1);
    assign is_single    = (req_dw_count == 11'd1);
    // Reads with a bad length are still answered (with UR), so only
    // non-read requests that are not a single-DW write are dropped here.
    assign hdr_drop     = !is_mrd && !(is_mwr && is_single);

    // Fields not interpreted by this completer (last_be, address type,
    // upper address, tkeep, the remaining tuser sidebands).
    assign unused_cq_bits = ^{m_axis_cq_tuser, m_axis_cq_tkeep, m_axis_cq_tdata};

    // Ready is held low while reset is asserted so nothing is accepted then.
    always_comb begin
        cq_ready = 1'b0;
        case (state_reg)
            ST_IDLE:  cq_ready = pcie_link_up;
            ST_HDR1:  cq_ready = 1'b1;
            ST_WDATA: cq_ready = 1'b1;
            ST_DRAIN: cq_ready = 1'b1;
            default:  cq_ready = 1'b0;
        endcase
        if (pcie_reset_out) begin
            cq_ready = 1'b0;
        end
    end

    assign m_axis_cq_tready = cq_ready;
    assign cq_fire          = m_axis_cq_tvalid && cq_ready;
    assign cc_fire          = s_axis_cc_tvalid && s_axis_cc_tready;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge pcie_clk_in) begin
        if (pcie_reset_out) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cq_fire) begin
                    if (cq_sop) begin
                        state_next = ST_HDR1;
                    end else if (!m_axis_cq_tlast) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_HDR1: begin
                if (cq_fire) begin
                    if (is_mrd) begin
                        state_next = ST_CPL0;
                    end else if (is_mwr && is_single) begin
                        state_next = ST_WDATA;
                    end else if (m_axis_cq_tlast) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_WDATA: begin
                if (cq_fire) begin
                    state_next = m_axis_cq_tlast ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cq_fire && m_axis_cq_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CPL0: begin
                if (cc_fire) begin
                    state_next = ST_CPL1;
                end
            end
            ST_CPL1: begin
                if (cc_fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Request field capture (data only, no reset needed)
    // -----------------------------------------------------------------------
    always_ff @(posedge pcie_clk_in) begin
        if (state_reg == ST_IDLE && cq_fire && cq_sop) begin
            addr_reg     <= m_axis_cq_tdata[AW_HI:2];
            first_be_reg <= m_axis_cq_tuser[3:0];
        end
        if (state_reg == ST_HDR1 && cq_fire) begin
            req_id_reg <= m_axis_cq_tdata[31:16];
            tag_reg    <= m_axis_cq_tdata[39:32];
            tc_reg     <= m_axis_cq_tdata[59:57];
            attr_reg   <= m_axis_cq_tdata[62:60];
            ur_reg     <= !is_single;
        end
    end

    // -----------------------------------------------------------------------
    // Counters
    // -----------------------------------------------------------------------
    always_ff @(posedge pcie_clk_in) begin
        if (pcie_reset_out) begin
            wr_cnt_reg   <= 32'd0;
            rd_cnt_reg   <= 32'd0;
            drop_cnt_reg <= 32'd0;
        end else begin
            if (state_reg == ST_WDATA && cq_fire) begin
                wr_cnt_reg <= wr_cnt_reg + 32'd1;
            end
            if (state_reg == ST_CPL1 && cc_fire && !ur_reg) begin
                rd_cnt_reg <= rd_cnt_reg + 32'd1;
            end
            if ((state_reg == ST_HDR1 && cq_fire && hdr_drop) ||
                (state_reg == ST_CPL1 && cc_fire && ur_reg)) begin
                drop_cnt_reg <= drop_cnt_reg + 32'd1;
            end
        end
    end

    assign wr_cnt   = wr_cnt_reg;
    assign rd_cnt   = rd_cnt_reg;
    assign drop_cnt = drop_cnt_reg;

    // -----------------------------------------------------------------------
    // Register file: one byte-wide RAM per lane so first_be maps directly to
    // independent lane write enables. The read port is registered and runs
    // every cycle, so by CPL1 it reflects any write that preceded the read.
    // -----------------------------------------------------------------------
    assign reg_idx = addr_reg[REG_AW+1:2];
    assign wr_en   = (state_reg == ST_WDATA) && cq_fire;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [0:DEPTH-1];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge pcie_clk_in) begin
                if (wr_en && first_be_reg[gi]) begin
                    mem[reg_idx] <= m_axis_cq_tdata[gi*8 +: 8];
                end
                rd_byte_reg <= mem[reg_idx];
            end

            assign rd_data[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Completion descriptor. Outputs are decoded from state and latched
    // fields only, so they hold while the CC sink stalls.
    // -----------------------------------------------------------------------
    assign cpl_dw0 = {3'b000, (ur_reg ? 13'd0 : 13'd4), 9'd0, addr_reg[6:2], 2'b00};
    assign cpl_dw1 = {req_id_reg, 2'b00, (ur_reg ? 3'b001 : 3'b000),
                      (ur_reg ? 11'd0 : 11'd1)};
    assign cpl_dw2 = {1'b0, attr_reg, tc_reg, 1'b0, cfg_completer_id, tag_reg};

    always_comb begin
        s_axis_cc_tvalid = 1'b0;
        s_axis_cc_tlast  = 1'b0;
        s_axis_cc_tkeep  = '0;
        s_axis_cc_tdata  = '0;
        case (state_reg)
            ST_CPL0: begin
                s_axis_cc_tvalid = 1'b1;
                s_axis_cc_tkeep  = 2'b11;
                s_axis_cc_tdata  = {cpl_dw1, cpl_dw0};
            end
            ST_CPL1: begin
                s_axis_cc_tvalid = 1'b1;
                s_axis_cc_tlast  = 1'b1;
                s_axis_cc_tkeep  = ur_reg ? 2'b01 : 2'b11;
                s_axis_cc_tdata  = {(ur_reg ? 32'h0 : rd_data), cpl_dw2};
            end
            default: ;
        endcase
    end

    assign s_axis_cc_tuser = '0;

endmodule

// File: tb/tb_pcie_cq_cc_responder.sv
module tb_pcie_cq_cc_responder;

    localparam logic [15:0] CID = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_up;
    logic [63:0] cq_tdata;
    logic [84:0] cq_tuser;
    logic        cq_tlast;
    logic [1:0]  cq_tkeep;
    logic        cq_tvalid;
    logic        cq_tready;
    logic [63:0] cc_tdata;
    logic [84:0] cc_tuser;
    logic        cc_tlast;
    logic [1:0]  cc_tkeep;
    logic        cc_tvalid;
    logic        cc_tready;
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;
    logic [31:0] drop_cnt;

    always #5 clk = ~clk;

    pcie_cq_cc_responder dut (
        .pcie_clk_in      (clk),
        .pcie_reset_out   (rst),
        .pcie_link_up     (link_up),
        .m_axis_cq_tdata  (cq_tdata),
        .m_axis_cq_tuser  (cq_tuser),
        .m_axis_cq_tlast  (cq_tlast),
        .m_axis_cq_tkeep  (cq_tkeep),
        .m_axis_cq_tvalid (cq_tvalid),
        .m_axis_cq_tready (cq_tready),
        .s_axis_cc_tdata  (cc_tdata),
        .s_axis_cc_tuser  (cc_tuser),
        .s_axis_cc_tlast  (cc_tlast),
        .s_axis_cc_tkeep  (cc_tkeep),
        .s_axis_cc_tvalid (cc_tvalid),
        .s_axis_cc_tready (cc_tready),
        .cfg_completer_id (CID),
        .wr_cnt           (wr_cnt),
        .rd_cnt           (rd_cnt),
        .drop_cnt         (drop_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: register contents and expected counters.
    logic [31:0] mdl_mem [64];
    logic [31:0] exp_wr;
    logic [31:0] exp_rd;
    logic [31:0] exp_drop;

    typedef struct {
        bit          is_wr;
        logic [63:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [10:0] dwc;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [2:0]  tc;
        logic [2:0]  attr;
        logic [31:0] e_dw0;
        logic [31:0] e_dw1;
        logic [31:0] e_dw2;
        logic [31:0] e_rdata;
        logic [1:0]  e_keep1;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: got no handshake within 200 cycles, expected one", name);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [84:0] u,
                             input logic [1:0] k, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        cq_tdata  = d;
        cq_tuser  = u;
        cq_tkeep  = k;
        cq_tlast  = l;
        cq_tvalid = 1'b1;
        while (!cq_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cq_tready) begin
            timeout_fail("cq_handshake");
            cq_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cq_tvalid = 1'b0;
        cq_tlast  = 1'b0;
    endtask

    task automatic send_req(input logic [63:0] addr, input logic [3:0] be,
                            input logic [3:0] rtype, input logic [10:0] dwc,
                            input logic [15:0] rid, input logic [7:0] tag,
                            input logic [2:0] tc, input logic [2:0] attr,
                            input logic last1);
        logic [84:0] u;
        logic [31:0] dw2;
        logic [31:0] dw3;
        u      = '0;
        u[40]  = 1'b1;
        u[3:0] = be;
        dw2 = {rid, 1'b0, rtype, dwc};
        dw3 = {1'b0, attr, tc, 17'h0, tag};
        send_beat(addr, u, 2'b11, 1'b0);
        send_beat({dw3, dw2}, '0, 2'b11, last1);
    endtask

    task automatic recv_beat(output logic [63:0] d, output logic [1:0] k, output logic l);
        int n;
        n = 0;
        @(negedge clk);
        cc_tready = 1'b1;
        while (!cc_tvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cc_tvalid) begin
            timeout_fail("cc_handshake");
            cc_tready = 1'b0;
            d = '0;
            k = '0;
            l = 1'b0;
            return;
        end
        d = cc_tdata;
        k = cc_tkeep;
        l = cc_tlast;
        @(posedge clk);
        #1;
        cc_tready = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [3:0] be, input logic [31:0] data);
        logic [31:0] entry;
        send_req(addr, be, 4'd1, 11'd1, 16'h00AA, 8'h00, 3'd0, 3'd0, 1'b0);
        send_beat({32'h0, data}, '0, 2'b01, 1'b1);
        entry = mdl_mem[addr[7:2]];
        for (int b = 0; b < 4; b++) begin
            if (be[b]) entry[b*8 +: 8] = data[b*8 +: 8];
        end
        mdl_mem[addr[7:2]] = entry;
        exp_wr = exp_wr + 32'd1;
        $display("txn MWr addr=0x%h be=%b data=0x%h", addr, be, data);
    endtask

    // Completion fields derived from the request with plain arithmetic.
    function automatic void exp_cpl(input logic [63:0] addr, input logic [10:0] dwc,
                                    input logic [15:0] rid, input logic [7:0] tag,
                                    input logic [2:0] tc, input logic [2:0] attr,
                                    output logic [31:0] dw0, output logic [31:0] dw1,
                                    output logic [31:0] dw2, output logic [31:0] rdata,
                                    output logic [1:0] keep1);
        bit sc;
        sc    = (dwc == 11'd1);
        dw0   = (sc ? (32'd4 << 16) : 32'd0) | (addr[31:0] & 32'h0000_007C);
        dw1   = (32'(rid) << 16) | (sc ? 32'd1 : (32'd1 << 11));
        dw2   = (32'(attr) << 28) | (32'(tc) << 25) | (32'(CID) << 8) | 32'(tag);
        rdata = sc ? mdl_mem[addr[7:2]] : 32'h0;
        keep1 = sc ? 2'b11 : 2'b01;
    endfunction

    task automatic read_core(input string name, input logic [63:0] addr, input logic [10:0] dwc,
                             input logic [15:0] rid, input logic [7:0] tag,
                             input logic [2:0] tc, input logic [2:0] attr, input int stall,
                             input logic [31:0] e_dw0, input logic [31:0] e_dw1,
                             input logic [31:0] e_dw2, input logic [31:0] e_rdata,
                             input logic [1:0] e_keep1);
        logic [63:0] b0, b1;
        logic [1:0]  k0, k1;
        logic        l0, l1;
        send_req(addr, 4'hF, 4'd0, dwc, rid, tag, tc, attr, 1'b1);
        @(negedge clk);
        check({name, "_latency"}, 64'(cc_tvalid), 64'd1);
        repeat (stall) @(negedge clk);
        recv_beat(b0, k0, l0);
        recv_beat(b1, k1, l1);
        check({name, "_beat0"}, b0, {e_dw1, e_dw0});
        check({name, "_beat0_keep_last"}, 64'({k0, l0}), 64'(3'b110));
        check({name, "_beat1"}, b1, {e_rdata, e_dw2});
        check({name, "_beat1_keep_last"}, 64'({k1, l1}), 64'({e_keep1, 1'b1}));
        if (dwc == 11'd1) exp_rd = exp_rd + 32'd1;
        else              exp_drop = exp_drop + 32'd1;
        $display("txn MRd addr=0x%h dwc=%0d tag=0x%h beat0=0x%h beat1=0x%h keep1=%b",
                 addr, dwc, tag, b0, b1, k1);
    endtask

    task automatic do_read(input string name, input logic [63:0] addr, input logic [10:0] dwc,
                           input logic [15:0] rid, input logic [7:0] tag,
                           input logic [2:0] tc, input logic [2:0] attr, input int stall);
        logic [31:0] d0, d1, d2, rd;
        logic [1:0]  k1;
        exp_cpl(addr, dwc, rid, tag, tc, attr, d0, d1, d2, rd, k1);
        read_core(name, addr, dwc, rid, tag, tc, attr, stall, d0, d1, d2, rd, k1);
    endtask

    task automatic check_counters(input string name);
        check({name, "_wr_cnt"}, 64'(wr_cnt), 64'(exp_wr));
        check({name, "_rd_cnt"}, 64'(rd_cnt), 64'(exp_rd));
        check({name, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] first_data;
        bit          held;
        bit          cq_seen;
        bit          seen_valid;
        logic [63:0] ra;

        rst = 1'b1; link_up = 1'b1;
        cq_tdata = '0; cq_tuser = '0; cq_tlast = 1'b0; cq_tkeep = '0; cq_tvalid = 1'b0;
        cc_tready = 1'b0;
        exp_wr = 0; exp_rd = 0; exp_drop = 0;
        for (int i = 0; i < 64; i++) mdl_mem[i] = 32'h0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_cq_tready", 64'(cq_tready), 64'd0);
        check("rst_cc_tvalid", 64'(cc_tvalid), 64'd0);
        check("rst_cc_keep_last", 64'({cc_tkeep, cc_tlast}), 64'd0);
        check("rst_cc_tdata", cc_tdata, 64'd0);
        check("rst_cc_tuser", 64'(|cc_tuser), 64'd0);
        check_counters("rst");
        rst = 1'b0;
        @(negedge clk);
        check("idle_cq_tready", 64'(cq_tready), 64'd1);

        // ---------------- directed table ----------------
        vecs[0] = '{1'b1, 64'h14, 4'hF, 32'hDEADBEEF, 11'd1, 16'h0, 8'h0, 3'd0, 3'd0,
                    32'h0, 32'h0, 32'h0, 32'h0, 2'b00};
        vecs[1] = '{1'b0, 64'h14, 4'hF, 32'h0, 11'd1, 16'h1234, 8'h3A, 3'd0, 3'd0,
                    32'h0004_0014, 32'h1234_0001, 32'h00A5_C33A, 32'hDEADBEEF, 2'b11};
        vecs[2] = '{1'b1, 64'h14, 4'b0011, 32'h0000_1234, 11'd1, 16'h0, 8'h0, 3'd0, 3'd0,
                    32'h0, 32'h0, 32'h0, 32'h0, 2'b00};
        vecs[3] = '{1'b0, 64'h14, 4'hF, 32'h0, 11'd1, 16'hBEEF, 8'h41, 3'd3, 3'd5,
                    32'h0004_0014, 32'hBEEF_0001, 32'h56A5_C341, 32'hDEAD1234, 2'b11};
        vecs[4] = '{1'b0, 64'h14, 4'hF, 32'h0, 11'd2, 16'h0042, 8'h07, 3'd0, 3'd1,
                    32'h0000_0014, 32'h0042_0800, 32'h10A5_C307, 32'h0, 2'b01};
        vecs[5] = '{1'b0, 64'h14, 4'hF, 32'h0, 11'd1, 16'hFFFF, 8'hFF, 3'd7, 3'd7,
                    32'h0004_0014, 32'hFFFF_0001, 32'h7EA5_C3FF, 32'hDEAD1234, 2'b11};
        vecs[6] = '{1'b1, 64'hFFFF_0000_0000_00FC, 4'hF, 32'h0123_4567, 11'd1, 16'h0, 8'h0,
                    3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00};
        vecs[7] = '{1'b1, 64'hFFFF_0000_0000_00FC, 4'b1000, 32'hAB00_0000, 11'd1, 16'h0, 8'h0,
                    3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00};
        vecs[8] = '{1'b0, 64'hFFFF_0000_0000_00FC, 4'hF, 32'h0, 11'd1, 16'h0001, 8'h10, 3'd0,
                    3'd0, 32'h0004_007C, 32'h0001_0001, 32'h00A5_C310, 32'hAB23_4567, 2'b11};

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].be, vecs[i].wdata);
            end else begin
                read_core($sformatf("vec%0d", i), vecs[i].addr, vecs[i].dwc, vecs[i].rid,
                          vecs[i].tag, vecs[i].tc, vecs[i].attr, 0, vecs[i].e_dw0,
                          vecs[i].e_dw1, vecs[i].e_dw2, vecs[i].e_rdata, vecs[i].e_keep1);
            end
        end
        check_counters("table");

        // ---------------- CC backpressure during CPL0 ----------------
        cc_tready = 1'b0;
        send_req(64'h14, 4'hF, 4'd0, 11'd1, 16'h5555, 8'h22, 3'd0, 3'd0, 1'b1);
        @(negedge clk);
        first_data = cc_tdata;
        held = 1'b1;
        cq_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cc_tdata !== first_data || !cc_tvalid) held = 1'b0;
            if (cq_tready) cq_seen = 1'b1;
        end
        check("stall_tdata_held", 64'(held), 64'd1);
        check("stall_cq_tready", 64'(cq_seen), 64'd0);
        check("stall_beat0", first_data, {32'h5555_0001, 32'h0004_0014});
        begin
            logic [63:0] b0, b1;
            logic [1:0]  k0, k1;
            logic        l0, l1;
            recv_beat(b0, k0, l0);
            recv_beat(b1, k1, l1);
            check("stall_beat1", b1, {32'hDEAD1234, 32'h00A5_C322});
            check("stall_keep_last", 64'({k0, l0, k1, l1}), 64'(6'b110111));
            check("stall_beat0_after", b0, first_data);
            exp_rd = exp_rd + 32'd1;
            $display("txn MRd stalled beat0=0x%h beat1=0x%h", b0, b1);
        end

        // ---------------- I/O request, 3 beats, drained ----------------
        send_req(64'h20, 4'hF, 4'd2, 11'd1, 16'h0777, 8'h09, 3'd0, 3'd0, 1'b0);
        send_beat(64'hCAFE_F00D_1111_2222, '0, 2'b11, 1'b1);
        exp_drop = exp_drop + 32'd1;
        seen_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cc_tvalid) seen_valid = 1'b1;
        end
        check("io_no_cpl", 64'(seen_valid), 64'd0);
        check("io_back_idle", 64'(cq_tready), 64'd1);
        check_counters("io");
        $display("txn IO request drained drop_cnt=%0d", drop_cnt);

        // ---------------- link down blocks acceptance ----------------
        link_up = 1'b0;
        @(negedge clk);
        check("linkdown_cq_tready", 64'(cq_tready), 64'd0);
        link_up = 1'b1;
        @(negedge clk);
        check("linkup_cq_tready", 64'(cq_tready), 64'd1);

        // ---------------- reset during CPL1 ----------------
        cc_tready = 1'b0;
        send_req(64'h14, 4'hF, 4'd0, 11'd1, 16'h7777, 8'h5A, 3'd0, 3'd0, 1'b1);
        @(negedge clk);
        check("rst_mid_cpl0_valid", 64'(cc_tvalid), 64'd1);
        cc_tready = 1'b1;
        @(posedge clk);
        #1;
        cc_tready = 1'b0;
        @(negedge clk);
        check("rst_mid_cpl1", 64'({cc_tvalid, cc_tlast}), 64'(2'b11));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_cc_tvalid", 64'(cc_tvalid), 64'd0);
        check("rst_mid_cq_tready", 64'(cq_tready), 64'd0);
        exp_wr = 0; exp_rd = 0; exp_drop = 0;
        check_counters("rst_mid");
        rst = 1'b0;
        $display("txn reset during CPL1");
        do_read("post_rst", 64'h14, 11'd1, 16'h3333, 8'h66, 3'd1, 3'd2, 1);
        check_counters("post_rst");

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 64; i++) begin
            do_write(64'(i * 4), 4'hF, $urandom);
        end
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            ra[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1) begin
                do_write(ra, 4'($urandom_range(0, 15)), $urandom);
            end else begin
                do_read($sformatf("rnd%0d", i), ra,
                        ($urandom_range(0, 5) == 0) ? 11'd2 : 11'd1,
                        16'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                        3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            end
        end
        check_counters("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
